// File: rtl/wb_sram.sv
// Wishbone B4 classic single-port SRAM slave with byte lanes, programmable wait states
// and error termination for misaligned or out-of-range accesses.
module wb_sram #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cyc_i,
  input  logic                    stb_i,
  input  logic                    we_i,
  input  logic [31:0]             adr_i,
  input  logic [DATA_WIDTH/8-1:0] sel_i,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  output logic [DATA_WIDTH-1:0]   dat_o,
  output logic                    ack_o,
  output logic                    err_o,
  output logic                    rty_o
);

  localparam int unsigned Lanes    = DATA_WIDTH / 8;
  localparam int unsigned OffW     = $clog2(Lanes);
  localparam int unsigned AddrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] MemBytes = 33'(DEPTH) * 33'(Lanes);
  localparam logic [31:0] LaneMask = 32'(Lanes - 1);
  localparam logic [3:0]  WaitLast = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic                    ack_q;
  logic                    err_q;
  logic [DATA_WIDTH-1:0]   dat_q;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic              req;
  logic              addr_ok;
  logic              accept;
  logic              mem_we;
  logic [31:0]       offset;
  logic [AddrW-1:0]  idx;

  always_comb begin
    req     = cyc_i & stb_i;
    offset  = adr_i - BASE_ADDR;
    addr_ok = (adr_i >= BASE_ADDR) && ({1'b0, offset} < MemBytes) &&
              ((offset & LaneMask) == 32'd0);
    idx     = AddrW'(offset >> OffW);
    // accept marks the edge that enters StResp: the transfer is committed here
    accept  = 1'b0;
    if (req) begin
      if (state_q == StIdle && WAIT_STATES == 0) begin
        accept = 1'b1;
      end else if (state_q == StWait && cnt_q == WaitLast) begin
        accept = 1'b1;
      end
    end
    mem_we = accept & we_i & addr_ok & ~rst_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
      if (accept) begin
        state_q <= StResp;
        ack_q   <= addr_ok;
        err_q   <= ~addr_ok;
        if (addr_ok && !we_i) begin
          dat_q <= mem_q[idx];
        end
      end else begin
        unique case (state_q)
          StIdle: begin
            if (req) begin
              state_q <= StWait;
              cnt_q   <= 4'd0;
            end
          end
          StWait: begin
            if (!req) begin
              state_q <= StIdle;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
          StResp:  state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // Memory is deliberately outside the reset domain so reset never disturbs contents.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int l = 0; l < Lanes; l++) begin
        if (sel_i[l]) begin
          mem_q[idx][8*l +: 8] <= dat_i[8*l +: 8];
        end
      end
    end
  end

  assign dat_o = dat_q;
  assign ack_o = ack_q;
  assign err_o = err_q;
  assign rty_o = 1'b0;

endmodule

// File: tb/tb_wb_sram.sv
// Self-checking bench for wb_sram: five parameterisations share one bus, selected by cyc.
module tb_wb_sram;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  cyc;
  logic        stb, we;
  logic [31:0] adr, dat_i;
  logic [3:0]  sel;
  logic [4:0]  ack, err, rty;
  logic [31:0] d0, d1, d2, d3;
  logic [15:0] d4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_sram u_d0 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc[0]), .stb_i(stb), .we_i(we), .adr_i(adr),
    .sel_i(sel), .dat_i(dat_i), .dat_o(d0), .ack_o(ack[0]), .err_o(err[0]), .rty_o(rty[0])
  );
  wb_sram #(.DEPTH(64), .WAIT_STATES(3)) u_d1 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc[1]), .stb_i(stb), .we_i(we), .adr_i(adr),
    .sel_i(sel), .dat_i(dat_i), .dat_o(d1), .ack_o(ack[1]), .err_o(err[1]), .rty_o(rty[1])
  );
  wb_sram #(.DEPTH(64), .BASE_ADDR(32'h0000_8000)) u_d2 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc[2]), .stb_i(stb), .we_i(we), .adr_i(adr),
    .sel_i(sel), .dat_i(dat_i), .dat_o(d2), .ack_o(ack[2]), .err_o(err[2]), .rty_o(rty[2])
  );
  wb_sram #(.DEPTH(64), .WAIT_STATES(2)) u_d3 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc[3]), .stb_i(stb), .we_i(we), .adr_i(adr),
    .sel_i(sel), .dat_i(dat_i), .dat_o(d3), .ack_o(ack[3]), .err_o(err[3]), .rty_o(rty[3])
  );
  wb_sram #(.DATA_WIDTH(16), .DEPTH(16)) u_d4 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc[4]), .stb_i(stb), .we_i(we), .adr_i(adr),
    .sel_i(sel[1:0]), .dat_i(dat_i[15:0]), .dat_o(d4), .ack_o(ack[4]), .err_o(err[4]),
    .rty_o(rty[4])
  );

  typedef struct {
    int unsigned inst;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic        e_ack;
    logic        e_err;
    logic [31:0] e_dat;
    int          e_lat;
  } vec_t;

  vec_t vecs[$];

  // Byte-addressed reference image of u_d0 (in-range bytes only).
  logic [7:0] model [4096];

  function automatic logic [31:0] rd_dat(input int k);
    case (k)
      0:       return d0;
      1:       return d1;
      2:       return d2;
      3:       return d3;
      default: return {16'h0, d4};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic xfer(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic g_ack, output logic g_err,
                      output logic [31:0] g_dat, output int lat);
    @(negedge clk);
    cyc[k] = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    lat = 0; g_ack = 1'b0; g_err = 1'b0; g_dat = '0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (ack[k] || err[k]) begin
        lat = n; g_ack = ack[k]; g_err = err[k]; g_dat = rd_dat(k);
        break;
      end
    end
    chk("ack_err_excl", 32'(ack[k] & err[k]), 32'd0);
    chk("rty_zero", 32'(rty[k]), 32'd0);
    cyc[k] = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    chk("term_one_cycle", 32'({ack[k], err[k]}), 32'd0);
    chk("dat_idle_zero", rd_dat(k), 32'd0);
  endtask

  logic        g_ack, g_err;
  logic [31:0] g_dat;
  int          lat;

  initial begin
    rst = 1'b1; cyc = '0; stb = 1'b0; we = 1'b0; adr = '0; dat_i = '0; sel = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("reset_ack%0d", k), 32'(ack[k]), 32'd0);
      chk($sformatf("reset_err%0d", k), 32'(err[k]), 32'd0);
      chk($sformatf("reset_dat%0d", k), rd_dat(k), 32'd0);
    end
    rst = 1'b0;

    // Back-to-back writes on the 16-bit instance with stb held: acks two cycles apart.
    @(negedge clk);
    cyc[4] = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0; dat_i = 32'h1111; sel = 4'b0011;
    @(posedge clk); #1;
    chk("b2b_ack1", 32'(ack[4]), 32'd1);
    adr = 32'h2; dat_i = 32'h2222;
    @(posedge clk); #1;
    chk("b2b_gap", 32'(ack[4]), 32'd0);
    @(posedge clk); #1;
    chk("b2b_ack2", 32'(ack[4]), 32'd1);
    cyc[4] = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    chk("b2b_end", 32'(ack[4]), 32'd0);

    vecs.push_back('{0, 1'b1, 32'h0,    32'h0123_4567, 4'hf, 1'b1, 1'b0, 32'h0, 1});
    vecs.push_back('{0, 1'b0, 32'h0,    32'h0,         4'hf, 1'b1, 1'b0, 32'h0123_4567, 1});
    vecs.push_back('{0, 1'b1, 32'h0,    32'hAABB_CCDD, 4'h5, 1'b1, 1'b0, 32'h0, 1});
    vecs.push_back('{0, 1'b0, 32'h0,    32'h0,         4'hf, 1'b1, 1'b0, 32'h01BB_45DD, 1});
    vecs.push_back('{0, 1'b0, 32'h1000, 32'h0,         4'hf, 1'b0, 1'b1, 32'h0, 1});
    vecs.push_back('{0, 1'b0, 32'h2,    32'h0,         4'hf, 1'b0, 1'b1, 32'h0, 1});
    vecs.push_back('{0, 1'b1, 32'h2,    32'hFFFF_FFFF, 4'hf, 1'b0, 1'b1, 32'h0, 1});
    vecs.push_back('{0, 1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hf, 1'b0, 1'b1, 32'h0, 1});
    vecs.push_back('{0, 1'b0, 32'h0,    32'h0,         4'hf, 1'b1, 1'b0, 32'h01BB_45DD, 1});
    vecs.push_back('{0, 1'b1, 32'h4,    32'h89AB_CDEF, 4'hf, 1'b1, 1'b0, 32'h0, 1});
    vecs.push_back('{0, 1'b1, 32'h4,    32'h0,         4'h0, 1'b1, 1'b0, 32'h0, 1});
    vecs.push_back('{0, 1'b0, 32'h4,    32'h0,         4'hf, 1'b1, 1'b0, 32'h89AB_CDEF, 1});
    vecs.push_back('{2, 1'b0, 32'h0,    32'h0,         4'hf, 1'b0, 1'b1, 32'h0, 1});
    vecs.push_back('{2, 1'b1, 32'h8000, 32'h55,        4'hf, 1'b1, 1'b0, 32'h0, 1});
    vecs.push_back('{2, 1'b0, 32'h8000, 32'h0,         4'hf, 1'b1, 1'b0, 32'h55, 1});
    vecs.push_back('{2, 1'b0, 32'h8100, 32'h0,         4'hf, 1'b0, 1'b1, 32'h0, 1});
    vecs.push_back('{1, 1'b1, 32'h4,    32'hCAFE_F00D, 4'hf, 1'b1, 1'b0, 32'h0, 4});
    vecs.push_back('{1, 1'b0, 32'h4,    32'h0,         4'hf, 1'b1, 1'b0, 32'hCAFE_F00D, 4});
    vecs.push_back('{4, 1'b0, 32'h0,    32'h0,         4'h3, 1'b1, 1'b0, 32'h1111, 1});
    vecs.push_back('{4, 1'b0, 32'h2,    32'h0,         4'h3, 1'b1, 1'b0, 32'h2222, 1});
    vecs.push_back('{4, 1'b0, 32'h20,   32'h0,         4'h3, 1'b0, 1'b1, 32'h0, 1});
    vecs.push_back('{4, 1'b0, 32'h1,    32'h0,         4'h3, 1'b0, 1'b1, 32'h0, 1});
    vecs.push_back('{4, 1'b1, 32'h1E,   32'hBEEF,      4'h3, 1'b1, 1'b0, 32'h0, 1});
    vecs.push_back('{4, 1'b0, 32'h1E,   32'h0,         4'h3, 1'b1, 1'b0, 32'hBEEF, 1});

    foreach (vecs[i]) begin
      xfer(int'(vecs[i].inst), vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].s,
           g_ack, g_err, g_dat, lat);
      chk($sformatf("vec%0d_ack", i), 32'(g_ack), 32'(vecs[i].e_ack));
      chk($sformatf("vec%0d_err", i), 32'(g_err), 32'(vecs[i].e_err));
      chk($sformatf("vec%0d_dat", i), g_dat, vecs[i].e_dat);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].e_lat));
    end

    // Three wait states: strobe drops after two wait cycles, transfer must vanish.
    @(negedge clk);
    cyc[1] = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h4; dat_i = 32'hDEAD_BEEF; sel = 4'hf;
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_pre", 32'({ack[1], err[1]}), 32'd0);
    end
    stb = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      chk("abort_post", 32'({ack[1], err[1]}), 32'd0);
    end
    cyc[1] = 1'b0;
    xfer(1, 1'b0, 32'h4, 32'h0, 4'hf, g_ack, g_err, g_dat, lat);
    chk("abort_keep_dat", g_dat, 32'hCAFE_F00D);
    chk("abort_idle_lat", 32'(lat), 32'd4);

    // Reset during the wait phase of a write; the request is then turned into a read.
    xfer(3, 1'b1, 32'h8, 32'h1111_2222, 4'hf, g_ack, g_err, g_dat, lat);
    chk("rst_pre_ack", 32'(g_ack), 32'd1);
    chk("rst_pre_lat", 32'(lat), 32'd3);
    @(negedge clk);
    cyc[3] = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h8; dat_i = 32'h3333_4444; sel = 4'hf;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_edge_term", 32'({ack[3], err[3]}), 32'd0);
    rst = 1'b0; we = 1'b0;
    lat = 0; g_dat = '0; g_ack = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (ack[3] || err[3]) begin
        lat = n; g_ack = ack[3]; g_dat = d3;
        break;
      end
    end
    cyc[3] = 1'b0; stb = 1'b0;
    chk("rst_after_lat", 32'(lat), 32'd3);
    chk("rst_after_ack", 32'(g_ack), 32'd1);
    chk("rst_old_data", g_dat, 32'h1111_2222);
    @(posedge clk); #1;

    // Randomised traffic on the default instance against the byte-level model.
    for (int w = 0; w <= 16; w++) begin
      logic [31:0] a;
      logic [31:0] v;
      a = (w == 16) ? 32'h0FFC : 32'(w * 4);
      v = $urandom;
      for (int b = 0; b < 4; b++) model[a + 32'(b)] = v[8*b +: 8];
      xfer(0, 1'b1, a, v, 4'hf, g_ack, g_err, g_dat, lat);
      chk("init_ack", 32'(g_ack), 32'd1);
    end
    for (int t = 0; t < 300; t++) begin
      logic [31:0] a;
      logic [31:0] v;
      logic [31:0] e_dat;
      logic [3:0]  s;
      logic        w;
      logic        bad;
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r <= 6)      a = 32'($urandom_range(0, 15) * 4);
      else if (r == 7) a = 32'h0FFC;
      else if (r == 8) a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else             a = 32'h1000 + ($urandom % 32'hFFFF_E000);
      w = 1'($urandom_range(0, 1));
      v = $urandom;
      s = 4'($urandom_range(0, 15));
      bad = (a >= 32'h1000) || (a % 4 != 0);
      e_dat = '0;
      if (!bad && w) begin
        for (int b = 0; b < 4; b++) if (s[b]) model[a + 32'(b)] = v[8*b +: 8];
      end else if (!bad) begin
        for (int b = 0; b < 4; b++) e_dat[8*b +: 8] = model[a + 32'(b)];
      end
      xfer(0, w, a, v, s, g_ack, g_err, g_dat, lat);
      chk($sformatf("rnd%0d_ack a=%h", t, a), 32'(g_ack), 32'(!bad));
      chk($sformatf("rnd%0d_err a=%h", t, a), 32'(g_err), 32'(bad));
      chk($sformatf("rnd%0d_dat a=%h", t, a), g_dat, e_dat);
      chk($sformatf("rnd%0d_lat", t), 32'(lat), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
